// File: rtl/hc595_pkg.sv
// Shared types and width helpers for the 74HC595 chain driver family.
package hc595_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_e;

  // Counter width that holds 0..n with headroom, so no wrap occurs inside a frame.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/hc595_phase_gen.sv
// Half-period tick generator: phase_end every DIV running cycles, level toggles on each tick.
module hc595_phase_gen
  import hc595_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic phase_end,
  output logic level
);

  localparam int PW = cnt_w(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt;

  assign phase_end = run && (cnt == LAST);

  // clear wins over run so a new frame or an exit always restarts from a low phase
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (run) begin
      if (phase_end) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hc595_chain_tx.sv
// Multi-chain 74HC595 frame shifter: one frame per handshake, shared shcp/stcp, per-chain ds.
module hc595_chain_tx
  import hc595_pkg::*;
#(
  parameter int CHAINS    = 6,
  parameter int BITS      = 8,
  parameter int DIV       = 2,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHAINS*BITS-1:0]   frame_data,
  input  logic                     frame_valid,
  output logic                     frame_ready,
  output logic                     shcp,
  output logic                     stcp,
  output logic [CHAINS-1:0]        ds,
  output logic                     busy,
  output logic                     done
);

  localparam int BW = cnt_w(BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS - 1);

  state_e state_q, state_n;

  logic [CHAINS*BITS-1:0] shadow_q, shadow_sh;
  logic [CHAINS-1:0]      head_in, head_sh;
  logic [BW-1:0]          bit_q;
  logic                   phase_end, run, clear, accept, bit_adv, last_bit;
  logic                   stcp_d, busy_d, done_d, ready_d;

  assign run      = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && frame_valid && frame_ready;
  assign bit_adv  = (state_q == SHIFT) && phase_end && shcp;
  assign last_bit = (bit_q == LAST_BIT);
  assign clear    = accept || ((state_q == LATCH) && phase_end);

  hc595_phase_gen #(.DIV(DIV)) u_phase (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .clear     (clear),
    .phase_end (phase_end),
    .level     (shcp)
  );

  // Shadow slices shift toward the output end, so ds always reads a fixed bit position.
  for (genvar c = 0; c < CHAINS; c++) begin : g_ch
    logic [BITS-1:0] s;
    assign s = shadow_q[c*BITS +: BITS];
    if (BITS == 1) begin : g_one
      assign shadow_sh[c*BITS +: BITS] = '0;
    end else if (LSB_FIRST) begin : g_lsb
      assign shadow_sh[c*BITS +: BITS] = {1'b0, s[BITS-1:1]};
    end else begin : g_msb
      assign shadow_sh[c*BITS +: BITS] = {s[BITS-2:0], 1'b0};
    end
    if (LSB_FIRST) begin : g_hl
      assign head_in[c] = frame_data[c*BITS];
      assign head_sh[c] = shadow_sh[c*BITS];
    end else begin : g_hm
      assign head_in[c] = frame_data[c*BITS + BITS - 1];
      assign head_sh[c] = shadow_sh[c*BITS + BITS - 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = SHIFT;
      SHIFT:   if (bit_adv && last_bit) state_n = LATCH;
      LATCH:   if (phase_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, keeping every pin glitch-free.
  always_comb begin
    stcp_d  = (state_n == LATCH);
    busy_d  = (state_n != IDLE);
    done_d  = (state_q == LATCH) && (state_n == IDLE);
    ready_d = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stcp        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      stcp        <= stcp_d;
      busy        <= busy_d;
      done        <= done_d;
      frame_ready <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      bit_q    <= '0;
      ds       <= '0;
    end else if (accept) begin
      shadow_q <= frame_data;
      bit_q    <= '0;
      ds       <= head_in;
    end else if (bit_adv && !last_bit) begin
      shadow_q <= shadow_sh;
      bit_q    <= bit_q + 1'b1;
      ds       <= head_sh;
    end
  end

endmodule

// File: tb/tb_hc595_chain_tx.sv
// Directed bench for hc595_chain_tx over four parameter sets sharing one clock and reset.
module tb_hc595_chain_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] fd0 = '0, fd1 = '0, fd2 = '0;
  logic [5:0]  fd3 = '0;
  logic        fv0 = 1'b0, fv1 = 1'b0, fv2 = 1'b0, fv3 = 1'b0;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic        sh0, sh1, sh2, sh3, st0, st1, st2, st3;
  logic        bz0, bz1, bz2, bz3, dn0, dn1, dn2, dn3;
  logic [1:0]  ds0, ds1, ds2;
  logic [5:0]  ds3;

  hc595_chain_tx #(.CHAINS(2), .BITS(8), .DIV(2), .LSB_FIRST(1'b0)) u0 (
    .clk(clk), .rst(rst), .frame_data(fd0), .frame_valid(fv0), .frame_ready(rdy0),
    .shcp(sh0), .stcp(st0), .ds(ds0), .busy(bz0), .done(dn0));
  hc595_chain_tx #(.CHAINS(2), .BITS(8), .DIV(2), .LSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst), .frame_data(fd1), .frame_valid(fv1), .frame_ready(rdy1),
    .shcp(sh1), .stcp(st1), .ds(ds1), .busy(bz1), .done(dn1));
  hc595_chain_tx #(.CHAINS(2), .BITS(8), .DIV(1), .LSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst), .frame_data(fd2), .frame_valid(fv2), .frame_ready(rdy2),
    .shcp(sh2), .stcp(st2), .ds(ds2), .busy(bz2), .done(dn2));
  hc595_chain_tx #(.CHAINS(6), .BITS(1), .DIV(3), .LSB_FIRST(1'b0)) u3 (
    .clk(clk), .rst(rst), .frame_data(fd3), .frame_valid(fv3), .frame_ready(rdy3),
    .shcp(sh3), .stcp(st3), .ds(ds3), .busy(bz3), .done(dn3));

  // Launches one frame on u0 (which=0) or u1 (which=1); returns sampling cycle 1.
  task automatic start01(input int which, input logic [15:0] data);
    if (which == 0) begin fd0 = data; fv0 = 1'b1; end
    else            begin fd1 = data; fv1 = 1'b1; end
    @(posedge clk); #1;
    fv0 = 1'b0; fv1 = 1'b0;
  endtask

  // Samples ncyc cycles of u0/u1 and gathers ds at shcp rises plus latch/done timing.
  task automatic capture01(input int which, input int ncyc, input bit disturb,
                           output logic [7:0] r0, output logic [7:0] r1, output int nrise,
                           output int st_first, output int st_last, output int st_pulses,
                           output int done_cyc, output int done_cnt,
                           output logic busy1, output logic busy_d, output logic ready_d);
    logic psh, pst, sh, st, dn, bz, rd;
    logic [1:0] d;
    psh = 0; pst = 0; r0 = '0; r1 = '0; nrise = 0; st_first = 0; st_last = 0;
    st_pulses = 0; done_cyc = 0; done_cnt = 0; busy1 = 0; busy_d = 1; ready_d = 0;
    for (int k = 1; k <= ncyc; k++) begin
      sh = which ? sh1 : sh0;  st = which ? st1 : st0;  dn = which ? dn1 : dn0;
      bz = which ? bz1 : bz0;  rd = which ? rdy1 : rdy0; d = which ? ds1 : ds0;
      if (sh && !psh) begin r0 = {r0[6:0], d[0]}; r1 = {r1[6:0], d[1]}; nrise++; end
      if (st) begin if (st_first == 0) st_first = k; st_last = k; end
      if (st && !pst) st_pulses++;
      if (k == 1) busy1 = bz;
      if (dn) begin done_cyc = k; done_cnt++; busy_d = bz; ready_d = rd; end
      psh = sh; pst = st;
      if (disturb && k == 5)  fd0 = 16'h5AC3;
      if (disturb && k == 10) fv0 = 1'b1;
      if (disturb && k == 11) fv0 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({rdy0, sh0, st0, ds0, bz0, dn0, rdy2, sh2, st2, ds2, bz2, dn2,
         rdy1, sh1, st1, ds1, bz1, dn1, rdy3, sh3, st3, ds3, bz3, dn3} !== '0) begin
      bad++;
      $display("FAIL reset_outputs actual=%b required=0",
               {rdy0, sh0, st0, ds0, bz0, dn0, rdy1, sh1, st1, ds1, bz1, dn1});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({rdy0, rdy1, rdy2, rdy3} !== 4'b1111) begin
      bad++; $display("FAIL ready_after_reset actual=%b required=1111", {rdy0, rdy1, rdy2, rdy3});
    end
  endtask

  task automatic frame01(input string name, input int which, input logic [15:0] data,
                         input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] r0, r1;
    int nr, sf, sl, sp, dc, dk;
    logic b1, bd, rd;
    start01(which, data);
    capture01(which, 40, 1'b0, r0, r1, nr, sf, sl, sp, dc, dk, b1, bd, rd);
    total++; if (r0 !== e0) begin bad++; $display("FAIL %s ds0 actual=%b required=%b", name, r0, e0); end
    total++; if (r1 !== e1) begin bad++; $display("FAIL %s ds1 actual=%b required=%b", name, r1, e1); end
    total++; if (nr != 8) begin bad++; $display("FAIL %s shcp_rises actual=%0d required=8", name, nr); end
    total++; if (sf != 33 || sl != 34) begin
      bad++; $display("FAIL %s stcp_window actual=%0d..%0d required=33..34", name, sf, sl); end
    total++; if (dc != 35 || dk != 1) begin
      bad++; $display("FAIL %s done actual=cyc%0d x%0d required=cyc35 x1", name, dc, dk); end
    total++; if ({b1, bd, rd} !== 3'b101) begin
      bad++; $display("FAIL %s busy1/busy_done/ready_done actual=%b required=101", name, {b1, bd, rd}); end
  endtask

  task automatic test_msb_first();
    frame01("msb_a53c", 0, 16'hA53C, 8'b00111100, 8'b10100101);
    frame01("msb_12c4", 0, 16'h12C4, 8'b11000100, 8'b00010010);
  endtask

  task automatic test_lsb_first();
    frame01("lsb_a53c", 1, 16'hA53C, 8'b00111100, 8'b10100101);
    frame01("lsb_12c4", 1, 16'h12C4, 8'b00100011, 8'b01001000);
  endtask

  task automatic test_no_requeue();
    logic [7:0] r0, r1;
    int nr, sf, sl, sp, dc, dk;
    logic b1, bd, rd;
    start01(0, 16'hA53C);
    capture01(0, 80, 1'b1, r0, r1, nr, sf, sl, sp, dc, dk, b1, bd, rd);
    total++; if ({r0, r1} !== 16'b00111100_10100101) begin
      bad++; $display("FAIL requeue_ds actual=%b required=0011110010100101", {r0, r1}); end
    total++; if (sp != 1) begin bad++; $display("FAIL requeue_stcp_pulses actual=%0d required=1", sp); end
    total++; if (dk != 1 || dc != 35) begin
      bad++; $display("FAIL requeue_done actual=cyc%0d x%0d required=cyc35 x1", dc, dk); end
  endtask

  task automatic test_back_to_back();
    int dcyc[3];
    int nd = 0, rerr = 0;
    logic exp_rdy;
    fd2 = 16'hF00F; fv2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 56; k++) begin
      exp_rdy = (k == 18 || k == 36 || k == 54 || k >= 55);
      if (rdy2 !== exp_rdy) rerr++;
      if (dn2) begin if (nd < 3) dcyc[nd] = k; nd++; end
      if (k == 54) fv2 = 1'b0;
      @(posedge clk); #1;
    end
    total++; if (nd != 3) begin bad++; $display("FAIL b2b_done_count actual=%0d required=3", nd); end
    else begin
      total++; if (dcyc[0] != 18 || dcyc[1] != 36 || dcyc[2] != 54) begin
        bad++; $display("FAIL b2b_done_cycles actual=%0d,%0d,%0d required=18,36,54", dcyc[0], dcyc[1], dcyc[2]); end
    end
    total++; if (rerr != 0) begin bad++; $display("FAIL b2b_ready_pattern actual_errors=%0d required=0", rerr); end
  endtask

  task automatic test_mid_reset();
    int stc = 0;
    start01(0, 16'hA53C);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({sh0, st0, ds0, bz0, dn0, rdy0} !== 7'b0) begin
      bad++; $display("FAIL midrst_outputs actual=%b required=0000000", {sh0, st0, ds0, bz0, dn0, rdy0}); end
    rst = 1'b0;
    @(posedge clk); #1;
    total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL midrst_ready actual=%b required=1", rdy0); end
    for (int k = 0; k < 50; k++) begin
      if (st0 || bz0) stc++;
      @(posedge clk); #1;
    end
    total++; if (stc != 0) begin bad++; $display("FAIL midrst_no_latch actual=%0d required=0", stc); end
  endtask

  task automatic test_single_bit();
    int nr = 0, rc = 0, sf = 0, sl = 0, dc = 0;
    logic psh = 1'b0;
    logic [5:0] dsr = '0;
    fd3 = 6'b101101; fv3 = 1'b1;
    @(posedge clk); #1;
    fv3 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (sh3 && !psh) begin nr++; rc = k; dsr = ds3; end
      if (st3) begin if (sf == 0) sf = k; sl = k; end
      if (dn3) dc = k;
      psh = sh3;
      @(posedge clk); #1;
    end
    total++; if (nr != 1 || rc != 4) begin
      bad++; $display("FAIL single_rise actual=x%0d@%0d required=x1@4", nr, rc); end
    total++; if (dsr !== 6'b101101) begin bad++; $display("FAIL single_ds actual=%b required=101101", dsr); end
    total++; if (sf != 7 || sl != 9) begin
      bad++; $display("FAIL single_stcp actual=%0d..%0d required=7..9", sf, sl); end
    total++; if (dc != 10) begin bad++; $display("FAIL single_done actual=%0d required=10", dc); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_no_requeue();
    test_back_to_back();
    test_mid_reset();
    test_single_bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
